ingress_reg_ctrl: RTL and testbench

INGRESS_REG_CTRL -- requirements
Module: ingress_reg_ctrl

---
 rtl/ingress_pkg.sv | 43 ++++
 rtl/ingress_rd_mux.sv | 82 ++++++++
 rtl/ingress_reg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ingress_reg_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_pkg.sv
// ingress_pkg -- shared definitions for the BAR0 register controller.
//   offs_e     : the 16 register offsets inside one channel window
//   state_e    : controller FSM states
//   MAX_CHNL   : largest supported channel count
//   ACK_*      : bit positions of the read side-effect one-hot from ingress_rd_mux
package ingress_pkg;

  localparam int MAX_CHNL = 16;

  typedef enum logic [3:0] {
    OFF_USR0        = 4'b0000,
    OFF_USR1        = 4'b0001,
    OFF_USR2        = 4'b0010,
    OFF_USR3        = 4'b0011,
    OFF_USR4        = 4'b0100,
    OFF_USR5        = 4'b0101,
    OFF_USR6        = 4'b0110,
    OFF_USR7        = 4'b0111,
    OFF_TX_LEN      = 4'b1000,
    OFF_TX_OFF_LAST = 4'b1001,
    OFF_LINK_INFO   = 4'b1010,
    OFF_INTR1       = 4'b1011,
    OFF_INTR2       = 4'b1100,
    OFF_RX_DONE     = 4'b1101,
    OFF_TX_DONE     = 4'b1110,
    OFF_FPGA_NAME   = 4'b1111
  } offs_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_CPL    = 2'd3
  } state_e;

  localparam int ACK_W       = 5;
  localparam int ACK_TX_LEN  = 0;
  localparam int ACK_RX_DONE = 1;
  localparam int ACK_TX_DONE = 2;
  localparam int ACK_INTR1   = 3;
  localparam int ACK_INTR2   = 4;

endpackage

// File: rtl/ingress_rd_mux.sv
// ingress_rd_mux -- combinational read-source selection.
//   chnl, offs       : decoded BAR0 address fields
//   *_i              : per-channel (32*CHNL_NUM) and global (32) read sources
//   rd_data          : selected 32-bit value (0 for user offsets / absent channels)
//   ack_sel          : one-hot of the read side effect tied to this offset;
//                      per-channel kinds only fire for implemented channels
module ingress_rd_mux
  import ingress_pkg::*;
#(
  parameter int          CHNL_NUM  = 4,
  parameter logic [31:0] FPGA_NAME = 32'h4158_4331
) (
  input  logic [3:0]            chnl,
  input  logic [3:0]            offs,
  input  logic [32*CHNL_NUM-1:0] tx_len_i,
  input  logic [32*CHNL_NUM-1:0] tx_off_last_i,
  input  logic [32*CHNL_NUM-1:0] rx_done_i,
  input  logic [32*CHNL_NUM-1:0] tx_done_i,
  input  logic [31:0]           link_info_i,
  input  logic [31:0]           intr1_i,
  input  logic [31:0]           intr2_i,
  output logic [31:0]           rd_data,
  output logic [ACK_W-1:0]      ack_sel
);

  logic        w_chnl_ok;
  logic [31:0] w_tx_len;
  logic [31:0] w_tx_off_last;
  logic [31:0] w_rx_done;
  logic [31:0] w_tx_done;

  assign w_chnl_ok = (32'(chnl) < CHNL_NUM);

  // Loop-based channel pick keeps every slice index in range even for
  // channel numbers above CHNL_NUM.
  always_comb begin
    w_tx_len      = '0;
    w_tx_off_last = '0;
    w_rx_done     = '0;
    w_tx_done     = '0;
    for (int c = 0; c < CHNL_NUM; c++) begin
      if (32'(chnl) == c) begin
        w_tx_len      = tx_len_i[c*32 +: 32];
        w_tx_off_last = tx_off_last_i[c*32 +: 32];
        w_rx_done     = rx_done_i[c*32 +: 32];
        w_tx_done     = tx_done_i[c*32 +: 32];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    ack_sel = '0;
    case (offs_e'(offs))
      OFF_TX_LEN: if (w_chnl_ok) begin
        rd_data             = w_tx_len;
        ack_sel[ACK_TX_LEN] = 1'b1;
      end
      OFF_TX_OFF_LAST: if (w_chnl_ok) rd_data = w_tx_off_last;
      OFF_RX_DONE: if (w_chnl_ok) begin
        rd_data              = w_rx_done;
        ack_sel[ACK_RX_DONE] = 1'b1;
      end
      OFF_TX_DONE: if (w_chnl_ok) begin
        rd_data              = w_tx_done;
        ack_sel[ACK_TX_DONE] = 1'b1;
      end
      OFF_LINK_INFO: rd_data = link_info_i;
      OFF_INTR1: begin
        rd_data            = intr1_i;
        ack_sel[ACK_INTR1] = 1'b1;
      end
      OFF_INTR2: begin
        rd_data            = intr2_i;
        ack_sel[ACK_INTR2] = 1'b1;
      end
      OFF_FPGA_NAME: rd_data = FPGA_NAME;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/ingress_reg_ctrl.sv
// ingress_reg_ctrl -- BAR0 register controller behind ingress_parse.
//   Request side : req_valid/req_ready plus req_wr, req_addr {chnl,offs,2'b00},
//                  req_data, req_tag, req_rid, req_tc, req_attr
//   Write side   : wr_data + one-cycle wr_strb (bit chnl*8+offs, offs 0..7)
//   Read sources : per-channel tx_len/tx_off_last/rx_done/tx_done, global
//                  link_info/intr1/intr2, constant FPGA_NAME
//   Side effects : one-cycle tx_len/rx_done/tx_done acks, intr1/intr2 clears
//   Completion   : cpl_valid/cpl_ready with cpl_data/tag/rid/tc/attr/lower_addr
//   Debug        : o_dbg_state mirrors the FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until then;
// ready may be low at any time. req_ready is high only in IDLE, and
// cpl_valid with all cpl_* stays asserted and unchanged until cpl_ready.
module ingress_reg_ctrl
  import ingress_pkg::*;
#(
  parameter int          CHNL_NUM  = 4,
  parameter logic [31:0] FPGA_NAME = 32'h4158_4331
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [9:0]             req_addr,
  input  logic [31:0]            req_data,
  input  logic [7:0]             req_tag,
  input  logic [15:0]            req_rid,
  input  logic [2:0]             req_tc,
  input  logic [1:0]             req_attr,
  output logic [31:0]            wr_data,
  output logic [8*CHNL_NUM-1:0]  wr_strb,
  input  logic [32*CHNL_NUM-1:0] tx_len_i,
  input  logic [32*CHNL_NUM-1:0] tx_off_last_i,
  input  logic [32*CHNL_NUM-1:0] rx_done_i,
  input  logic [32*CHNL_NUM-1:0] tx_done_i,
  input  logic [31:0]            link_info_i,
  input  logic [31:0]            intr1_i,
  input  logic [31:0]            intr2_i,
  output logic [CHNL_NUM-1:0]    tx_len_ack,
  output logic [CHNL_NUM-1:0]    rx_done_ack,
  output logic [CHNL_NUM-1:0]    tx_done_ack,
  output logic                   intr1_clr,
  output logic                   intr2_clr,
  output logic                   cpl_valid,
  input  logic                   cpl_ready,
  output logic [31:0]            cpl_data,
  output logic [7:0]             cpl_tag,
  output logic [15:0]            cpl_rid,
  output logic [2:0]             cpl_tc,
  output logic [1:0]             cpl_attr,
  output logic [6:0]             cpl_lower_addr,
  output state_e                 o_dbg_state
);

  localparam int SW = 8 * CHNL_NUM;

  state_e                r_state;
  logic                  r_ready;
  logic [3:0]            r_chnl;
  logic [3:0]            r_offs;
  logic [31:0]           r_wr_data;
  logic [SW-1:0]         r_wr_strb;
  logic [CHNL_NUM-1:0]   r_tx_len_ack;
  logic [CHNL_NUM-1:0]   r_rx_done_ack;
  logic [CHNL_NUM-1:0]   r_tx_done_ack;
  logic                  r_intr1_clr;
  logic                  r_intr2_clr;
  logic                  r_cpl_valid;
  logic [31:0]           r_cpl_data;
  logic [7:0]            r_cpl_tag;
  logic [15:0]           r_cpl_rid;
  logic [2:0]            r_cpl_tc;
  logic [1:0]            r_cpl_attr;
  logic [6:0]            r_cpl_lower_addr;

  logic                  w_accept;
  logic [3:0]            w_chnl;
  logic [3:0]            w_offs;
  logic [3:0]            w_sel_chnl;
  logic [3:0]            w_sel_offs;
  logic                  w_wr_ok;
  logic [SW-1:0]         w_strb_one;
  logic [CHNL_NUM-1:0]   w_chnl_one;
  logic [31:0]           w_rd_data;
  logic [ACK_W-1:0]      w_ack_sel;
  logic                  w_unused_addr;

  assign w_accept      = r_ready & req_valid;
  assign w_chnl        = req_addr[9:6];
  assign w_offs        = req_addr[5:2];
  assign w_unused_addr = ^req_addr[1:0];

  // The mux sees the live request in IDLE so the side-effect pulse can be
  // registered at the accept edge and sit in the RD_CAP cycle; afterwards it
  // sees the captured address so RD_CAP registers the same source.
  assign w_sel_chnl = (r_state == ST_IDLE) ? w_chnl : r_chnl;
  assign w_sel_offs = (r_state == ST_IDLE) ? w_offs : r_offs;

  assign w_wr_ok    = (32'(w_chnl) < CHNL_NUM) && !w_offs[3];
  assign w_strb_one = SW'(1) << {w_chnl, w_offs[2:0]};
  assign w_chnl_one = CHNL_NUM'(1) << w_sel_chnl;

  ingress_rd_mux #(
    .CHNL_NUM  (CHNL_NUM),
    .FPGA_NAME (FPGA_NAME)
  ) u_rd_mux (
    .chnl          (w_sel_chnl),
    .offs          (w_sel_offs),
    .tx_len_i      (tx_len_i),
    .tx_off_last_i (tx_off_last_i),
    .rx_done_i     (rx_done_i),
    .tx_done_i     (tx_done_i),
    .link_info_i   (link_info_i),
    .intr1_i       (intr1_i),
    .intr2_i       (intr2_i),
    .rd_data       (w_rd_data),
    .ack_sel       (w_ack_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_ready          <= 1'b0;
      r_chnl           <= '0;
      r_offs           <= '0;
      r_wr_data        <= '0;
      r_wr_strb        <= '0;
      r_tx_len_ack     <= '0;
      r_rx_done_ack    <= '0;
      r_tx_done_ack    <= '0;
      r_intr1_clr      <= 1'b0;
      r_intr2_clr      <= 1'b0;
      r_cpl_valid      <= 1'b0;
      r_cpl_data       <= '0;
      r_cpl_tag        <= '0;
      r_cpl_rid        <= '0;
      r_cpl_tc         <= '0;
      r_cpl_attr       <= '0;
      r_cpl_lower_addr <= '0;
    end else begin
      // Pulses default low; only the accept edge raises them for one cycle.
      r_wr_strb     <= '0;
      r_tx_len_ack  <= '0;
      r_rx_done_ack <= '0;
      r_tx_done_ack <= '0;
      r_intr1_clr   <= 1'b0;
      r_intr2_clr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            if (req_wr) begin
              // Dropped writes still pass through WR, with no strobe.
              r_state <= ST_WR;
              if (w_wr_ok) begin
                r_wr_strb <= w_strb_one;
                r_wr_data <= req_data;
              end
            end else begin
              r_state          <= ST_RD_CAP;
              r_chnl           <= w_chnl;
              r_offs           <= w_offs;
              r_cpl_tag        <= req_tag;
              r_cpl_rid        <= req_rid;
              r_cpl_tc         <= req_tc;
              r_cpl_attr       <= req_attr;
              r_cpl_lower_addr <= {req_addr[6:2], 2'b00};
              r_tx_len_ack     <= w_ack_sel[ACK_TX_LEN]  ? w_chnl_one : '0;
              r_rx_done_ack    <= w_ack_sel[ACK_RX_DONE] ? w_chnl_one : '0;
              r_tx_done_ack    <= w_ack_sel[ACK_TX_DONE] ? w_chnl_one : '0;
              r_intr1_clr      <= w_ack_sel[ACK_INTR1];
              r_intr2_clr      <= w_ack_sel[ACK_INTR2];
            end
          end
        end
        ST_WR: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        ST_RD_CAP: begin
          r_cpl_data  <= w_rd_data;
          r_cpl_valid <= 1'b1;
          r_state     <= ST_CPL;
        end
        ST_CPL: begin
          if (cpl_ready) begin
            r_cpl_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = r_ready;
  assign wr_data        = r_wr_data;
  assign wr_strb        = r_wr_strb;
  assign tx_len_ack     = r_tx_len_ack;
  assign rx_done_ack    = r_rx_done_ack;
  assign tx_done_ack    = r_tx_done_ack;
  assign intr1_clr      = r_intr1_clr;
  assign intr2_clr      = r_intr2_clr;
  assign cpl_valid      = r_cpl_valid;
  assign cpl_data       = r_cpl_data;
  assign cpl_tag        = r_cpl_tag;
  assign cpl_rid        = r_cpl_rid;
  assign cpl_tc         = r_cpl_tc;
  assign cpl_attr       = r_cpl_attr;
  assign cpl_lower_addr = r_cpl_lower_addr;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ingress_reg_ctrl.sv
module tb_ingress_reg_ctrl;
  import ingress_pkg::*;

  localparam int CN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [9:0]    req_addr;
  logic [31:0]   req_data;
  logic [7:0]    req_tag;
  logic [15:0]   req_rid;
  logic [2:0]    req_tc;
  logic [1:0]    req_attr;
  logic [31:0]   wr_data;
  logic [8*CN-1:0] wr_strb;
  logic [32*CN-1:0] tx_len_i, tx_off_last_i, rx_done_i, tx_done_i;
  logic [31:0]   link_info_i, intr1_i, intr2_i;
  logic [CN-1:0] tx_len_ack, rx_done_ack, tx_done_ack;
  logic          intr1_clr, intr2_clr;
  logic          cpl_valid;
  logic          cpl_ready;
  logic [31:0]   cpl_data;
  logic [7:0]    cpl_tag;
  logic [15:0]   cpl_rid;
  logic [2:0]    cpl_tc;
  logic [1:0]    cpl_attr;
  logic [6:0]    cpl_lower_addr;
  state_e        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  ingress_reg_ctrl #(.CHNL_NUM(CN), .FPGA_NAME(32'h4158_4331)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .req_rid(req_rid), .req_tc(req_tc), .req_attr(req_attr),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .tx_len_i(tx_len_i), .tx_off_last_i(tx_off_last_i),
    .rx_done_i(rx_done_i), .tx_done_i(tx_done_i),
    .link_info_i(link_info_i), .intr1_i(intr1_i), .intr2_i(intr2_i),
    .tx_len_ack(tx_len_ack), .rx_done_ack(rx_done_ack), .tx_done_ack(tx_done_ack),
    .intr1_clr(intr1_clr), .intr2_clr(intr2_clr),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
    .cpl_tag(cpl_tag), .cpl_rid(cpl_rid), .cpl_tc(cpl_tc), .cpl_attr(cpl_attr),
    .cpl_lower_addr(cpl_lower_addr), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // checking and driver tasks
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {tx_len_ack, rx_done_ack, tx_done_ack, intr1_clr, intr2_clr}
  function automatic logic [13:0] side_fx();
    return {tx_len_ack, rx_done_ack, tx_done_ack, intr1_clr, intr2_clr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic wr, input logic [9:0] addr,
                       input logic [31:0] data, input logic [7:0] tg);
    check({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    req_tag   = tg;
    req_rid   = {8'hC0, tg};
    req_tc    = tg[2:0];
    req_attr  = tg[4:3];
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_check(input string tag, input logic [9:0] addr, input logic [31:0] data,
                             input logic [31:0] exp_strb, input logic [31:0] exp_wr_data);
    issue(tag, 1'b1, addr, data, 8'h00);
    check({tag, "_strb"}, wr_strb, exp_strb);
    check({tag, "_wdata"}, wr_data, exp_wr_data);
    check({tag, "_busy"}, req_ready, 1'b0);
    check({tag, "_nocpl"}, cpl_valid, 1'b0);
    tick();
    check({tag, "_strb_off"}, wr_strb, 32'h0);
    check({tag, "_idle"}, req_ready, 1'b1);
    check({tag, "_nocpl2"}, cpl_valid, 1'b0);
  endtask

  task automatic check_cpl(input string tag, input logic [31:0] exp_data,
                           input logic [7:0] tg, input logic [6:0] laddr);
    check({tag, "_cvalid"}, cpl_valid, 1'b1);
    check({tag, "_cdata"}, cpl_data, exp_data);
    check({tag, "_ctag"}, cpl_tag, tg);
    check({tag, "_crid"}, cpl_rid, {8'hC0, tg});
    check({tag, "_ctc"}, cpl_tc, tg[2:0]);
    check({tag, "_cattr"}, cpl_attr, tg[4:3]);
    check({tag, "_claddr"}, cpl_lower_addr, laddr);
  endtask

  task automatic read_check(input string tag, input logic [9:0] addr, input logic [7:0] tg,
                            input logic [31:0] exp_data, input logic [13:0] exp_fx);
    issue(tag, 1'b0, addr, 32'h0, tg);
    check({tag, "_fx"}, side_fx(), exp_fx);
    check({tag, "_n1_cvalid"}, cpl_valid, 1'b0);
    check({tag, "_n1_busy"}, req_ready, 1'b0);
    tick();
    check({tag, "_n2_fx"}, side_fx(), 14'h0);
    check({tag, "_n2_strb"}, wr_strb, 32'h0);
    check_cpl(tag, exp_data, tg, {addr[6:2], 2'b00});
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    check({tag, "_done_cvalid"}, cpl_valid, 1'b0);
    check({tag, "_done_ready"}, req_ready, 1'b1);
  endtask

  // directed stimulus
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    req_tag = '0; req_rid = '0; req_tc = '0; req_attr = '0; cpl_ready = 1'b0;
    tx_len_i      = {32'h0000_0033, 32'h0000_0100, 32'h0000_0022, 32'h0000_0011};
    tx_off_last_i = {32'h0000_0004, 32'h0000_0003, 32'hBEEF_0001, 32'h0000_0001};
    rx_done_i     = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    tx_done_i     = {32'h0000_D0E3, 32'h0000_D0E2, 32'h0000_D0E1, 32'h0000_D0E0};
    link_info_i   = 32'h4C1A_0007;
    intr1_i       = 32'h1234_5678;
    intr2_i       = 32'h0000_BEE2;

    // reset state
    repeat (3) tick();
    check("rst_ready", req_ready, 1'b0);
    check("rst_cvalid", cpl_valid, 1'b0);
    check("rst_strb", wr_strb, 32'h0);
    check("rst_wdata", wr_data, 32'h0);
    check("rst_fx", side_fx(), 14'h0);
    check("rst_cdata", cpl_data, 32'h0);
    check("rst_claddr", cpl_lower_addr, 7'h0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", req_ready, 1'b1);

    // writes: chnl 1 offs 1 -> bit 9; back-to-back chnl 3 offs 7 and chnl 0 offs 0
    write_check("wr_c1o1", 10'h044, 32'hDEAD_BEEF, 32'h0000_0200, 32'hDEAD_BEEF);
    write_check("wr_c3o7", 10'h0DC, 32'h1111_0001, 32'h8000_0000, 32'h1111_0001);
    write_check("wr_c0o0", 10'h000, 32'h2222_0002, 32'h0000_0001, 32'h2222_0002);

    // reads with per-channel and global sources
    read_check("rd_txlen_c2", 10'h0A0, 8'h5A, 32'h0000_0100, {4'b0100, 4'b0000, 4'b0000, 2'b00});
    read_check("rd_txoff_c1", 10'h064, 8'h11, 32'hBEEF_0001, 14'h0);
    read_check("rd_txdone_c3", 10'h0F8, 8'h23, 32'h0000_D0E3, {4'b0000, 4'b0000, 4'b1000, 2'b00});
    read_check("rd_link_c7", 10'h1E8, 8'h3C, 32'h4C1A_0007, 14'h0);
    read_check("rd_intr1", 10'h02C, 8'h47, 32'h1234_5678, 14'b10);
    read_check("rd_intr2_c2", 10'h0B0, 8'h09, 32'h0000_BEE2, 14'b01);
    read_check("rd_usr_c1o3", 10'h04C, 8'h6E, 32'h0, 14'h0);

    // dropped writes: offs 1011, then chnl 5 offs 0; wr_data keeps last value
    write_check("wr_drop_o11", 10'h02C, 32'hCAFE_0011, 32'h0, 32'h2222_0002);
    tick();
    check("wr_drop_o11_nocpl", cpl_valid, 1'b0);
    read_check("rd_rxdone_c5", 10'h174, 8'h15, 32'h0, 14'h0);
    write_check("wr_drop_c5", 10'h140, 32'hCAFE_0005, 32'h0, 32'h2222_0002);

    // FPGA name with a stalled consumer; a pending write request must not be taken
    issue("rd_name", 1'b0, 10'h0FC, 32'h0, 8'h77);
    check("rd_name_fx", side_fx(), 14'h0);
    tick();
    check_cpl("rd_name", 32'h4158_4331, 8'h77, 7'h7C);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h044; req_data = 32'h0000_FFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("name_hold_valid", cpl_valid, 1'b1);
      check("name_hold_data", cpl_data, 32'h4158_4331);
      check("name_hold_busy", req_ready, 1'b0);
      check("name_hold_quiet", {side_fx(), wr_strb}, 46'h0);
    end
    req_valid = 1'b0;
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    check("name_done_cvalid", cpl_valid, 1'b0);
    check("name_done_ready", req_ready, 1'b1);
    check("name_done_wdata", wr_data, 32'h2222_0002);

    // reset while a completion is pending
    issue("rd_rst", 1'b0, 10'h074, 32'h0, 8'h2B);
    check("rd_rst_fx", side_fx(), {4'b0000, 4'b0010, 4'b0000, 2'b00});
    tick();
    check("rd_rst_cvalid", cpl_valid, 1'b1);
    check("rd_rst_cdata", cpl_data, 32'hA5A5_0001);
    rst_n = 1'b0;
    tick();
    check("rst_cpl_cvalid", cpl_valid, 1'b0);
    check("rst_cpl_ready", req_ready, 1'b0);
    check("rst_cpl_fx", side_fx(), 14'h0);
    check("rst_cpl_cdata", cpl_data, 32'h0);
    check("rst_cpl_wdata", wr_data, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_cpl_rel_ready", req_ready, 1'b1);
    check("rst_cpl_rel_cvalid", cpl_valid, 1'b0);
    check("rst_cpl_rel_fx", side_fx(), 14'h0);

    // controller usable again after reset
    read_check("rd_after_rst", 10'h0A0, 8'h5B, 32'h0000_0100, {4'b0100, 4'b0000, 4'b0000, 2'b00});

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
